// File: rtl/data_mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// load_align reuses these, and so can any future cache path.
package data_mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_SIZE     = 2'b11
    } err_code_e;

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Combinational lane select plus sign/zero extension of a raw memory word.
module load_align
    import data_mem_lsu_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] raw_word,
    input  logic [1:0]           lane,
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    output logic [BIT_WIDTH-1:0] data
);

    logic [BIT_WIDTH-1:0] shifted;
    logic                 sign_byte;
    logic                 sign_half;

    always_comb begin
        shifted   = raw_word >> {lane, 3'b000};
        sign_byte = ~is_unsigned & shifted[7];
        sign_half = ~is_unsigned & shifted[15];
        data      = raw_word;
        case (size)
            SZ_BYTE: data = {{(BIT_WIDTH-8){sign_byte}}, shifted[7:0]};
            SZ_HALF: data = {{(BIT_WIDTH-16){sign_half}}, shifted[15:0]};
            default: data = raw_word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory for the MEM stage: byte-lane stores, extended
// sub-word loads, fault checking and a 1- or 2-cycle valid-tagged response.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [BIT_WIDTH-1:0] Data_In,
    output logic [BIT_WIDTH-1:0] Data_Out,
    output logic                 rsp_valid,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int IDX_W = $clog2(DEPTH);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("data_mem_lsu: READ_LATENCY must be 1 or 2");
    end

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]     word_idx;
    logic [1:0]           lane;
    logic                 out_of_range;
    err_code_e            fault_code;
    logic                 faulted;
    logic                 accept_store;
    logic                 accept_load;
    logic [3:0]           byte_en;
    logic [BIT_WIDTH-1:0] wr_data;

    assign word_idx = addr[IDX_W+1:2];
    assign lane     = addr[1:0];

    if (ADDR_W > IDX_W + 2) begin : g_range
        assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    // Fault priority: illegal size, then misalignment, then range.
    always_comb begin
        fault_code = ERR_NONE;
        if (req_size == SZ_ILLEGAL)
            fault_code = ERR_SIZE;
        else if ((req_size == SZ_HALF && lane[0]) || (req_size == SZ_WORD && lane != 2'b00))
            fault_code = ERR_MISALIGN;
        else if (out_of_range)
            fault_code = ERR_RANGE;
    end

    assign faulted      = (fault_code != ERR_NONE);
    assign accept_store = req_valid & req_we & ~faulted & ~rst;
    assign accept_load  = req_valid & ~req_we & ~faulted;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = Data_In;
        case (req_size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{Data_In[7:0]}};
            end
            SZ_HALF: begin
                byte_en = 4'b0011 << lane;
                wr_data = {2{Data_In[15:0]}};
            end
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    logic                 s1_valid;
    logic                 s1_err;
    err_code_e            s1_code;
    logic [BIT_WIDTH-1:0] s1_raw;
    logic [1:0]           s1_lane;
    logic [1:0]           s1_size;
    logic                 s1_unsigned;
    logic [BIT_WIDTH-1:0] aligned;

    // A faulted load captures a zero word so the aligned result is zero for any size.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_err      <= 1'b0;
            s1_code     <= ERR_NONE;
            s1_raw      <= '0;
            s1_lane     <= 2'b00;
            s1_size     <= 2'b00;
            s1_unsigned <= 1'b0;
        end else begin
            s1_valid <= req_valid & ~req_we;
            s1_err   <= req_valid & faulted;
            s1_code  <= req_valid ? fault_code : ERR_NONE;
            if (accept_load) begin
                s1_raw      <= mem[word_idx];
                s1_lane     <= lane;
                s1_size     <= req_size;
                s1_unsigned <= req_unsigned;
            end else if (req_valid & ~req_we) begin
                s1_raw <= '0;
            end
        end
    end

    load_align #(.BIT_WIDTH(BIT_WIDTH)) u_align (
        .raw_word    (s1_raw),
        .lane        (s1_lane),
        .size        (s1_size),
        .is_unsigned (s1_unsigned),
        .data        (aligned)
    );

    if (READ_LATENCY == 1) begin : g_lat1
        assign Data_Out  = aligned;
        assign rsp_valid = s1_valid;
        assign err       = s1_err;
        assign err_code  = s1_code;
    end else begin : g_lat2
        logic [BIT_WIDTH-1:0] out_data;
        logic                 out_valid;
        logic                 out_err;
        logic [1:0]           out_code;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_data  <= '0;
                out_valid <= 1'b0;
                out_err   <= 1'b0;
                out_code  <= 2'b00;
            end else begin
                out_valid <= s1_valid;
                out_err   <= s1_err;
                out_code  <= s1_code;
                if (s1_valid)
                    out_data <= aligned;
            end
        end

        assign Data_Out  = out_data;
        assign rsp_valid = out_valid;
        assign err       = out_err;
        assign err_code  = out_code;
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: two instances (latency 1 and 2) share the
// request bus so every vector is checked against both response timings.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] Data_In;

    logic [31:0] d1_out, d2_out;
    logic        d1_rsp, d2_rsp;
    logic        d1_err, d2_err;
    logic [1:0]  d1_code, d2_code;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.BIT_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .Data_In(Data_In),
        .Data_Out(d1_out), .rsp_valid(d1_rsp), .err(d1_err), .err_code(d1_code)
    );

    data_mem_lsu #(.BIT_WIDTH(32), .DEPTH(1024), .READ_LATENCY(2), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .Data_In(Data_In),
        .Data_Out(d2_out), .rsp_valid(d2_rsp), .err(d2_err), .err_code(d2_code)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] din;
        logic        exp_rsp;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(string name, logic we, logic [1:0] size, logic uns,
                                   logic [31:0] a, logic [31:0] din, logic exp_rsp,
                                   logic [31:0] exp_data, logic exp_err, logic [1:0] exp_code);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = a; v.din = din;
        v.exp_rsp = exp_rsp; v.exp_data = exp_data; v.exp_err = exp_err; v.exp_code = exp_code;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkDut(input string tag, input logic rsp, input logic e, input logic [1:0] code,
                            input logic [31:0] data, input vec_t v);
        checkOutput({tag, "/", v.name, "/rsp_valid"}, {31'd0, rsp}, {31'd0, v.exp_rsp});
        checkOutput({tag, "/", v.name, "/err"}, {31'd0, e}, {31'd0, v.exp_err});
        if (v.exp_rsp)
            checkOutput({tag, "/", v.name, "/Data_Out"}, data, v.exp_data);
        if (v.exp_err)
            checkOutput({tag, "/", v.name, "/err_code"}, {30'd0, code}, {30'd0, v.exp_code});
    endtask

    task automatic driveReq(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] a, input logic [31:0] din);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; addr = a; Data_In = din;
    endtask

    task automatic driveIdle();
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        addr = 32'h0; Data_In = 32'h0;
    endtask

    // One request, then the latency-1 slot and the latency-2 slot are sampled in turn.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveReq(v.we, v.size, v.uns, v.addr, v.din);
        @(negedge clk);
        driveIdle();
        checkDut("L1", d1_rsp, d1_err, d1_code, d1_out, v);
        @(negedge clk);
        checkDut("L2", d2_rsp, d2_err, d2_code, d2_out, v);
        checkOutput({"L1/", v.name, "/rsp_pulse"}, {31'd0, d1_rsp | d1_err}, 32'd0);
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic [31:0] bb_addr [4];
    logic [31:0] bb_exp  [4];

    initial begin
        rst = 1'b1;
        driveIdle();

        vecs.push_back(mkVec("st_w10",   1, W, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("ld_w10",   0, W, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0, 2'b00));
        vecs.push_back(mkVec("st_w10b",  1, W, 0, 32'h10,   32'h11223344, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("st_b13",   1, B, 0, 32'h13,   32'h00000080, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("ld_sb13",  0, B, 0, 32'h13,   32'h0,        1, 32'hFFFFFF80, 0, 2'b00));
        vecs.push_back(mkVec("ld_ub13",  0, B, 1, 32'h13,   32'h0,        1, 32'h00000080, 0, 2'b00));
        vecs.push_back(mkVec("ld_w10c",  0, W, 0, 32'h10,   32'h0,        1, 32'h80223344, 0, 2'b00));
        vecs.push_back(mkVec("ld_sb10",  0, B, 0, 32'h10,   32'h0,        1, 32'h00000044, 0, 2'b00));
        vecs.push_back(mkVec("ld_ub11",  0, B, 1, 32'h11,   32'h0,        1, 32'h00000033, 0, 2'b00));
        vecs.push_back(mkVec("ld_sh12",  0, H, 0, 32'h12,   32'h0,        1, 32'hFFFF8022, 0, 2'b00));
        vecs.push_back(mkVec("st_w20",   1, W, 0, 32'h20,   32'h55667788, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("st_h22",   1, H, 0, 32'h22,   32'h1234BEEF, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("ld_sh22",  0, H, 0, 32'h22,   32'h0,        1, 32'hFFFFBEEF, 0, 2'b00));
        vecs.push_back(mkVec("ld_uh22",  0, H, 1, 32'h22,   32'h0,        1, 32'h0000BEEF, 0, 2'b00));
        vecs.push_back(mkVec("ld_sh20",  0, H, 0, 32'h20,   32'h0,        1, 32'h00007788, 0, 2'b00));
        vecs.push_back(mkVec("ld_w20",   0, W, 0, 32'h20,   32'h0,        1, 32'hBEEF7788, 0, 2'b00));
        vecs.push_back(mkVec("ld_mis21", 0, H, 0, 32'h21,   32'h0,        1, 32'h00000000, 1, 2'b01));
        vecs.push_back(mkVec("st_mis22", 1, W, 0, 32'h22,   32'hFFFFFFFF, 0, 32'h0,        1, 2'b01));
        vecs.push_back(mkVec("ld_w20b",  0, W, 0, 32'h20,   32'h0,        1, 32'hBEEF7788, 0, 2'b00));
        vecs.push_back(mkVec("st_w00",   1, W, 0, 32'h0,    32'hCAFEF00D, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("st_rng",   1, W, 0, 32'h1000, 32'h12345678, 0, 32'h0,        1, 2'b10));
        vecs.push_back(mkVec("ld_w00",   0, W, 0, 32'h0,    32'h0,        1, 32'hCAFEF00D, 0, 2'b00));
        vecs.push_back(mkVec("ld_rng",   0, B, 0, 32'h2000, 32'h0,        1, 32'h00000000, 1, 2'b10));
        vecs.push_back(mkVec("ld_ill",   0, X, 0, 32'h0,    32'h0,        1, 32'h00000000, 1, 2'b11));
        vecs.push_back(mkVec("st_ill",   1, X, 0, 32'h0,    32'h0,        0, 32'h0,        1, 2'b11));
        vecs.push_back(mkVec("ld_w00b",  0, W, 0, 32'h0,    32'h0,        1, 32'hCAFEF00D, 0, 2'b00));
        vecs.push_back(mkVec("pri_ill",  0, X, 0, 32'h1001, 32'h0,        1, 32'h00000000, 1, 2'b11));
        vecs.push_back(mkVec("pri_mis",  0, W, 0, 32'h1002, 32'h0,        1, 32'h00000000, 1, 2'b01));
        vecs.push_back(mkVec("st_wffc",  1, W, 0, 32'hFFC,  32'hA1B2C3D4, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("ld_ubfff", 0, B, 1, 32'hFFF,  32'h0,        1, 32'h000000A1, 0, 2'b00));
        vecs.push_back(mkVec("ld_shffe", 0, H, 0, 32'hFFE,  32'h0,        1, 32'hFFFFA1B2, 0, 2'b00));
        vecs.push_back(mkVec("st_w04",   1, W, 0, 32'h4,    32'h44444444, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("st_w08",   1, W, 0, 32'h8,    32'h88888888, 0, 32'h0,        0, 2'b00));
        vecs.push_back(mkVec("st_w0c",   1, W, 0, 32'hC,    32'h0CCCCCCC, 0, 32'h0,        0, 2'b00));

        repeat (3) @(negedge clk);
        checkOutput("reset/L1_out", {d1_out[31:1], d1_out[0] | d1_rsp | d1_err | (|d1_code)}, 32'h0);
        checkOutput("reset/L2_out", {d2_out[31:1], d2_out[0] | d2_rsp | d2_err | (|d2_code)}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset/L1_rsp", {31'd0, d1_rsp}, 32'd0);
        checkOutput("post_reset/L2_rsp", {31'd0, d2_rsp}, 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Four back-to-back loads: responses must arrive on consecutive cycles, in order.
        bb_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        bb_exp  = '{32'hCAFEF00D, 32'h44444444, 32'h88888888, 32'h0CCCCCCC};
        @(negedge clk);
        driveReq(1'b0, W, 1'b0, bb_addr[0], 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k - 1 < 4) begin
                checkOutput($sformatf("bb/L1_rsp%0d", k - 1), {31'd0, d1_rsp}, 32'd1);
                checkOutput($sformatf("bb/L1_data%0d", k - 1), d1_out, bb_exp[k-1]);
            end else begin
                checkOutput("bb/L1_idle", {31'd0, d1_rsp}, 32'd0);
            end
            if (k >= 2) begin
                checkOutput($sformatf("bb/L2_rsp%0d", k - 2), {31'd0, d2_rsp}, 32'd1);
                checkOutput($sformatf("bb/L2_data%0d", k - 2), d2_out, bb_exp[k-2]);
            end else begin
                checkOutput("bb/L2_first_idle", {31'd0, d2_rsp}, 32'd0);
            end
            if (k < 4) driveReq(1'b0, W, 1'b0, bb_addr[k], 32'h0);
            else driveIdle();
        end

        // Store immediately followed by a load of the same word.
        @(negedge clk);
        driveReq(1'b1, W, 1'b0, 32'h30, 32'h0BADCAFE);
        @(negedge clk);
        driveReq(1'b0, W, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        driveIdle();
        checkOutput("rdw/L1_rsp", {31'd0, d1_rsp}, 32'd1);
        checkOutput("rdw/L1_data", d1_out, 32'h0BADCAFE);
        @(negedge clk);
        checkOutput("rdw/L2_rsp", {31'd0, d2_rsp}, 32'd1);
        checkOutput("rdw/L2_data", d2_out, 32'h0BADCAFE);
        checkOutput("hold/L1_rsp", {31'd0, d1_rsp}, 32'd0);
        checkOutput("hold/L1_data", d1_out, 32'h0BADCAFE);
        @(negedge clk);
        checkOutput("hold/L2_rsp", {31'd0, d2_rsp}, 32'd0);
        checkOutput("hold/L2_data", d2_out, 32'h0BADCAFE);

        // Reset arriving the cycle after a load drops the latency-2 response.
        @(negedge clk);
        driveReq(1'b0, W, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        driveIdle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid/L2_rsp", {31'd0, d2_rsp}, 32'd0);
        checkOutput("rst_mid/L2_data", d2_out, 32'h0);
        checkOutput("rst_mid/L2_err", {29'd0, d2_err, d2_code}, 32'd0);
        checkOutput("rst_mid/L1_data", d1_out, 32'h0);
        checkOutput("rst_mid/L1_rsp", {31'd0, d1_rsp}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after/L2_rsp", {31'd0, d2_rsp}, 32'd0);
        checkOutput("rst_after/L2_data", d2_out, 32'h0);

        applyStimulus(mkVec("ld_survive", 0, W, 0, 32'h10, 32'h0, 1, 32'h80223344, 0, 2'b00));
        applyStimulus(mkVec("ld_survive30", 0, W, 0, 32'h30, 32'h0, 1, 32'h0BADCAFE, 0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor to the single-word data memory.
- Byte-addressed, synchronous-read data memory with byte-lane writes, sub-word loads with sign/zero extension, and misalignment/range checking.
- Configurable read latency (1 or 2 cycles), with a valid-tagged response path.
- Sits in the MEM stage of the pipelined CPU, between ALU address output and the WB mux.

Parameters:
- BIT_WIDTH, 32, data word width in bits; must be 32 (4 byte lanes).
- DEPTH, 1024, number of words; power of two.
- READ_LATENCY, 1, cycles from accepted load to rsp_valid; legal values 1 or 2.
- ADDR_W, 32, width of the byte address input.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- addr  input  ADDR_W  byte address
- Data_In  input  BIT_WIDTH  store data, right-aligned
- Data_Out  output  BIT_WIDTH  load result, extended
- rsp_valid  output  1  Data_Out is valid for one cycle
- err  output  1  one-cycle pulse flagging a faulted request, aligned with the response slot
- err_code  output  2  00 none, 01 misaligned, 10 out of range, 11 illegal size

Behaviour:
- Reset:
  - Data_Out=0, rsp_valid=0, err=0, err_code=00.
  - Latency pipeline registers are cleared; in-flight loads are discarded.
  - Memory array contents are NOT reset.
- Addressing:
  - word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0].
  - Out of range when any addr bit above log2(DEPTH)+1 is set.
- Fault priority: illegal size > misaligned > out of range.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Faulted request:
  - No array write occurs.
  - Load or store: err pulses READ_LATENCY cycles after acceptance, with the code above.
  - A faulted load also asserts rsp_valid with Data_Out=0.
  - A faulted store asserts only err.
- Store (req_valid & req_we, no fault): at the same posedge, write the lanes selected by size and lane.
  - Byte: Data_In[7:0] goes to the addressed lane.
  - Halfword: Data_In[15:0] goes to lanes {lane+1, lane}.
  - Word: all lanes.
  - Unselected lanes are unchanged.
  - No rsp_valid.
- Load (req_valid & ~req_we, no fault):
  - Array is read at the accepting posedge; raw word and lane/size/unsigned are captured.
  - Lane extraction and extension happen in the final stage.
  - READ_LATENCY=1: Data_Out/rsp_valid are valid in the cycle after acceptance.
  - READ_LATENCY=2: one extra output register stage.
  - rsp_valid is high exactly one cycle per accepted load; back-to-back loads give back-to-back responses. Throughput is 1 request per cycle, with no stall.
- Read-during-write: a load to a word stored in the immediately preceding cycle returns the new data. A store and a load cannot coincide (single port).
- Data_Out holds its last value when rsp_valid=0.
- Reset asserted mid-operation: takes effect at the next posedge. Any response due in that cycle or later is dropped, and no write occurs in the reset cycle.
- req_size=11 is illegal, even for stores.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), err_code constants, and the LATENCY legality check.
- Sub-module: load_align (combinational lane select plus sign/zero extend, with lane/size/unsigned inputs). It is reused by any future cache path.
- Byte-lane write-enable generation stays inline.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 → rsp_valid after READ_LATENCY cycles, Data_Out=0xDEADBEEF, err=0.
- Byte lanes: store byte 0x80 at 0x13 over word 0x11223344, then load signed byte at 0x13 → 0xFFFFFF80. Load unsigned → 0x00000080. Load word at 0x10 → 0x80223344.
- Halfword: store 0xBEEF at 0x22, load signed half at 0x22 → 0xFFFFBEEF. Misaligned half load at 0x21 → rsp_valid=1, Data_Out=0, err=1, err_code=01, memory unchanged.
- Range and size: with DEPTH=1024, a word store at 0x1000 gives err_code=10 and no write (a later load at 0x0000 is unchanged). req_size=11 gives err_code=11.
- Pipelining: issue 4 back-to-back loads at 0x0, 0x4, 0x8, 0xC, with READ_LATENCY=1 and then 2 → 4 consecutive rsp_valid cycles in order. Also check a store followed immediately by a load of the same word → new data.
- Reset mid-flight: with READ_LATENCY=2, issue a load then assert rst the next cycle → no rsp_valid, all outputs 0. Previously stored data survives reset.
